// File: rtl/mem_wait_controller_pkg.sv
// Shared types and address decoding for the wait-state data-memory stage.
// Imported by the controller; holds the FSM state enum and the byte-address to word-index mapping.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int MAP_W      = 64;

  typedef struct packed {
    logic [MAP_W-1:0] word_idx;
    logic             in_range;
  } addr_map_t;

  // Offset from base wraps at addr_w bits, so addresses below the base land far out of range.
  function automatic addr_map_t map_address(
    input logic [MAP_W-1:0] addr,
    input logic [MAP_W-1:0] base,
    input int unsigned      addr_w,
    input int unsigned      depth,
    input int unsigned      data_w
  );
    logic [MAP_W-1:0] mask;
    logic [MAP_W-1:0] diff;
    int               shamt;
    addr_map_t        m;
    mask  = (addr_w >= MAP_W) ? '1 : ((MAP_W'(1) << addr_w) - MAP_W'(1));
    diff  = (addr - base) & mask;
    shamt = 0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) < (data_w / 8)) shamt = i + 1;
    end
    m.word_idx = diff >> shamt;
    m.in_range = m.word_idx < MAP_W'(depth);
    return m;
  endfunction

endpackage

// File: rtl/mem_wait_controller_if.sv
// Handshake between the EXE/MEM register (master) and the data-memory stage (slave).
// Request, address and store data flow in; read data and access status flow back.
interface mem_wait_controller_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              freeze;
  logic              err;

  modport master (
    output mem_r_en, mem_w_en, address, wdata,
    input  rdata, ready, freeze, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, wdata,
    output rdata, ready, freeze, err
  );
endinterface

// File: rtl/mem_wait_controller_data_sram.sv
// Word store for the data-memory stage: synchronous write, asynchronous read, no reset.
// All access timing is decided by the controller that drives these ports.
module data_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_wait_controller.sv
// Data-memory stage with WAIT_CYCLES extra access cycles; freezes the front of the pipeline while busy.
// WAIT_CYCLES == 0 collapses to a combinational-read, zero-stall memory.
module mem_wait_controller
  import arm_mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(1024),
  parameter int                DEPTH       = 64,
  parameter int                WAIT_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst,
  mem_wait_controller_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  addr_map_t         live_map;
  logic [IDX_W-1:0]  live_idx;
  logic              unused_idx_hi;
  logic              req;

  logic              sram_we;
  logic [IDX_W-1:0]  sram_waddr;
  logic [IDX_W-1:0]  sram_raddr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  assign live_map      = map_address(MAP_W'(bus.address), MAP_W'(BASE_ADDR), ADDR_W, DEPTH, DATA_W);
  assign live_idx      = live_map.word_idx[IDX_W-1:0];
  assign unused_idx_hi = &{1'b0, live_map.word_idx[MAP_W-1:IDX_W]};
  assign req           = bus.mem_r_en | bus.mem_w_en;

  data_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk     (clk),
    .we_i    (sram_we),
    .waddr_i (sram_waddr),
    .wdata_i (sram_wdata),
    .raddr_i (sram_raddr),
    .rdata_o (sram_rdata)
  );

  if (WAIT_CYCLES == 0) begin : g_bypass
    assign sram_we    = rst & bus.mem_w_en & live_map.in_range;
    assign sram_waddr = live_idx;
    assign sram_raddr = live_idx;
    assign sram_wdata = bus.wdata;
    assign bus.rdata  = (rst & live_map.in_range) ? sram_rdata : '0;
    assign bus.ready  = rst & req;
    assign bus.err    = rst & req & ~live_map.in_range;
    assign bus.freeze = 1'b0;
  end else begin : g_fsm
    state_e                state_q,    state_d;
    logic [WAIT_CNT_W-1:0] cnt_q,      cnt_d;
    logic                  is_write_q, is_write_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [DATA_W-1:0]     wdata_q,    wdata_d;
    logic                  in_range_q, in_range_d;
    logic [DATA_W-1:0]     rdata_q,    rdata_d;
    logic                  freeze_c;
    logic                  ready_c;
    logic                  err_c;
    logic                  last_wait;

    assign last_wait = (state_q == WAIT) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        is_write_q <= 1'b0;
        idx_q      <= '0;
        wdata_q    <= '0;
        in_range_q <= 1'b0;
        rdata_q    <= '0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        is_write_q <= is_write_d;
        idx_q      <= idx_d;
        wdata_q    <= wdata_d;
        in_range_q <= in_range_d;
        rdata_q    <= rdata_d;
      end
    end

    // Only IDLE samples the bus; WAIT and DONE run purely on the latched request.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_write_d = is_write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      in_range_d = in_range_q;
      rdata_d    = rdata_q;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            is_write_d = bus.mem_w_en;
            idx_d      = live_idx;
            wdata_d    = bus.wdata;
            in_range_d = live_map.in_range;
            cnt_d      = WAIT_CNT_W'(WAIT_CYCLES - 1);
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (!is_write_q) rdata_d = in_range_q ? sram_rdata : '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      freeze_c = 1'b0;
      ready_c  = 1'b0;
      err_c    = 1'b0;
      unique case (state_q)
        IDLE: freeze_c = req;
        WAIT: freeze_c = 1'b1;
        DONE: begin
          ready_c = 1'b1;
          err_c   = ~in_range_q;
        end
        default: freeze_c = 1'b0;
      endcase
    end

    assign sram_we    = last_wait & is_write_q & in_range_q;
    assign sram_waddr = idx_q;
    assign sram_raddr = idx_q;
    assign sram_wdata = wdata_q;

    assign bus.freeze = rst & freeze_c;
    assign bus.ready  = ready_c;
    assign bus.err    = err_c;
    assign bus.rdata  = rdata_q;
  end
endmodule

// File: tb/tb_mem_wait_controller.sv
// Bench for mem_wait_controller: a 3-wait-state instance and a zero-wait instance,
// driven by directed and random accesses against a word-array reference model.
module tb_mem_wait_controller;
  localparam int WC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_wait_controller_if #(.DATA_W(32), .ADDR_W(32)) bus  ();
  mem_wait_controller_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

  mem_wait_controller #(.WAIT_CYCLES(WC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_wait_controller #(.WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] ref_mem  [64];
  logic [31:0] ref_mem0 [64];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Word index relative to base 1024, 4-byte words, 64 entries, unsigned 32-bit wrap.
  function automatic bit ref_map(input logic [31:0] a, output int idx);
    logic [31:0] words;
    words = (a - 32'd1024) / 32'd4;
    idx   = int'(words[5:0]);
    return words < 32'd64;
  endfunction

  task automatic clear_bus();
    bus.mem_w_en = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.address  = '0;
    bus.wdata    = '0;
  endtask

  // Entered and left just after a rising edge; the request is visible for one cycle only.
  task automatic acc(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input bit wig);
    int idx;
    bit ok;
    ok = ref_map(a, idx);
    bus.mem_w_en = w;
    bus.mem_r_en = r;
    bus.address  = a;
    bus.wdata    = d;
    for (int c = 0; c <= WC; c++) begin
      @(negedge clk);
      chk_b("freeze_busy", bus.freeze, 1'b1);
      chk_b("ready_busy", bus.ready, 1'b0);
      chk("rdata_hold", bus.rdata, last_rd);
      @(posedge clk); #1;
      if (wig) begin
        bus.address  = $urandom;
        bus.wdata    = $urandom;
        bus.mem_w_en = 1'($urandom_range(0, 1));
        bus.mem_r_en = 1'($urandom_range(0, 1));
      end else begin
        clear_bus();
      end
    end
    if (w) begin
      if (ok) ref_mem[idx] = d;
    end else begin
      last_rd = ok ? ref_mem[idx] : 32'd0;
    end
    @(negedge clk);
    chk_b("freeze_done", bus.freeze, 1'b0);
    chk_b("ready_done", bus.ready, 1'b1);
    chk_b("err_done", bus.err, !ok);
    chk("rdata_done", bus.rdata, last_rd);
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic acc0(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    int idx;
    bit ok;
    ok = ref_map(a, idx);
    bus0.mem_w_en = w;
    bus0.mem_r_en = r;
    bus0.address  = a;
    bus0.wdata    = d;
    @(negedge clk);
    chk_b("b_freeze", bus0.freeze, 1'b0);
    chk_b("b_ready", bus0.ready, w | r);
    chk_b("b_err", bus0.err, (w | r) & !ok);
    if (r && !w) chk("b_rdata", bus0.rdata, ok ? ref_mem0[idx] : 32'd0);
    @(posedge clk); #1;
    if (w && ok) ref_mem0[idx] = d;
    bus0.mem_w_en = 1'b0;
    bus0.mem_r_en = 1'b0;
    bus0.address  = '0;
    bus0.wdata    = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'd1024 - 32'($urandom_range(1, 32));
      1:       return 32'd1280 + 32'($urandom_range(0, 64));
      default: return 32'd1024 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int op;
    last_rd = '0;
    clear_bus();
    bus0.mem_w_en = 1'b0;
    bus0.mem_r_en = 1'b0;
    bus0.address  = '0;
    bus0.wdata    = '0;

    // Reset with a request present: no stall, no status.
    bus.mem_r_en = 1'b1;
    bus.mem_w_en = 1'b1;
    bus.address  = 32'd1024;
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_freeze", bus.freeze, 1'b0);
    chk_b("rst_ready", bus.ready, 1'b0);
    chk_b("rst_err", bus.err, 1'b0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk_b("rst_b_ready", bus0.ready, 1'b0);
    clear_bus();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) acc(1'b1, 1'b0, 32'd1024 + 32'(4 * i), $urandom, 1'b0);
    for (int i = 0; i < 64; i++) acc0(1'b1, 1'b0, 32'd1024 + 32'(4 * i), $urandom);

    acc(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    acc(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    chk("deadbeef_read", bus.rdata, 32'hDEADBEEF);

    acc(1'b0, 1'b1, 32'd1280, 32'h0, 1'b0);
    acc(1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 1'b0);
    acc(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

    acc(1'b1, 1'b0, 32'd1044, 32'hCAFEF00D, 1'b1);
    acc(1'b0, 1'b1, 32'd1044, 32'h0, 1'b0);
    chk("wiggle_read", bus.rdata, 32'hCAFEF00D);

    acc(1'b1, 1'b1, 32'd1040, 32'h000000A5, 1'b0);
    acc(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
    chk("both_en_read", bus.rdata, 32'h000000A5);

    // Reset during WAIT discards the pending write.
    acc(1'b1, 1'b0, 32'd1036, 32'h00001111, 1'b0);
    bus.mem_w_en = 1'b1;
    bus.address  = 32'd1036;
    bus.wdata    = 32'h00001234;
    @(negedge clk);
    chk_b("midrst_freeze_pre", bus.freeze, 1'b1);
    @(posedge clk); #1;
    clear_bus();
    rst = 1'b0;
    #1;
    chk_b("midrst_freeze", bus.freeze, 1'b0);
    chk_b("midrst_ready", bus.ready, 1'b0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    last_rd = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    acc(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    chk("midrst_read", bus.rdata, 32'h00001111);

    acc0(1'b1, 1'b0, 32'd1032, 32'h5);
    acc0(1'b0, 1'b1, 32'd1032, 32'h0);
    acc0(1'b0, 1'b0, 32'd1032, 32'h0);
    acc0(1'b0, 1'b1, 32'd1280, 32'h0);
    acc0(1'b1, 1'b0, 32'd1020, 32'h77);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      acc(op != 0, op != 1, rand_addr(), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      acc0(op == 1 || op == 2, op == 0 || op == 2, rand_addr(), $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_wait_controller.md
# mem_wait_controller

Parametrised data-memory stage for the ARM pipeline: it replaces the fixed single-cycle data memory with a word-addressed store that can model a configurable number of wait states. While an access is in progress it drives a freeze signal that stalls the IF/ID/EXE stages and the EXE/MEM register. With WAIT_CYCLES = 0 it degenerates to the zero-wait, never-freezing behaviour of the current memory stage. It sits between the EXE/MEM stage register and the MEM/WB stage register.

## Interface
- DATA_W, 32, data word width in bits (multiple of 8)
- ADDR_W, 32, byte-address width
- BASE_ADDR, 1024, byte address mapped to word 0
- DEPTH, 64, number of DATA_W words stored
- WAIT_CYCLES, 3, extra access cycles; legal range 0–15

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- mem_r_en  in  1  read request from the EXE/MEM register
- mem_w_en  in  1  write request from the EXE/MEM register
- address  in  ADDR_W  byte address (ALU result)
- wdata  in  DATA_W  store data (forwarded Rm value)
- rdata  out  DATA_W  read result to the MEM/WB register
- ready  out  1  access completes this cycle
- freeze  out  1  pipeline stall request, OR-ed with the hazard stall at the top level
- err  out  1  out-of-range access completes this cycle

## Operation
- Word index is (address − BASE_ADDR) >> log2(DATA_W/8). Low byte-offset bits are ignored. The arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W.
- An access is in range iff the word index is < DEPTH, interpreting the subtraction result as unsigned. Out-of-range reads return 0, out-of-range writes are dropped, and err is asserted together with ready.
- If mem_r_en and mem_w_en are both high, the request is a write. The read is ignored.
- WAIT_CYCLES = 0:
  - No state machine; freeze is always 0.
  - ready = mem_r_en | mem_w_en.
  - rdata is combinational from the array.
  - A write commits at the clock edge.
- WAIT_CYCLES ≥ 1 uses the FSM IDLE → WAIT → DONE:
  - IDLE: freeze = req (req = mem_r_en | mem_w_en), computed combinationally. If req is high, latch op, word index, wdata and the range flag, load cnt = WAIT_CYCLES−1, and go to WAIT.
  - WAIT: freeze = 1. If cnt == 0: commit the latched write, or load rdata from the array (0 if out of range), then go to DONE. Otherwise decrement cnt.
  - DONE: freeze = 0, ready = 1, err = latched out-of-range flag. Go to IDLE unconditionally.
- Only latched values are used after IDLE. Input changes during WAIT or DONE have no effect.
- rdata holds its last loaded value until the next read completes. Writes do not alter rdata.

## Timing
- Reset values: state IDLE, cnt 0, rdata 0, ready 0, err 0. freeze is 0 whenever rst is low. Array contents are not reset.
- Request first visible in cycle T (state IDLE):
  - freeze is high in cycles T … T+WAIT_CYCLES.
  - ready, and err if applicable, are high in cycle T+WAIT_CYCLES+1.
  - rdata is valid from T+WAIT_CYCLES+1 onward.
  - The write is committed at the edge ending cycle T+WAIT_CYCLES.
- Total access cost is WAIT_CYCLES+2 cycles, with WAIT_CYCLES+1 of them stalled.
- Back-to-back accesses: a new request present in the cycle after DONE starts immediately. A request can never be accepted during DONE itself.
- Reset asserted mid-access: the FSM returns to IDLE and any pending write is discarded (never committed). Reset released with a request present: the access starts normally the next cycle.
- freeze is the only combinational input-to-output path. There is no combinational path from inputs to ready, rdata or err when WAIT_CYCLES ≥ 1.

## Structure
- Package arm_mem_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - a WAIT_CNT_W constant of 4 bits;
  - a function computing the word index and in-range flag from address, BASE_ADDR, DEPTH and DATA_W.
- Sub-module data_sram: DEPTH × DATA_W array with a synchronous write port and an asynchronous read port. It has no reset. The controller owns all timing.
- A generate branch on WAIT_CYCLES == 0 selects the bypass path.

## Test plan
- Defaults: write 0xDEADBEEF to 1028, then read 1028. Require freeze high for 4 cycles on each access, ready pulsing in the 5th, and rdata = 0xDEADBEEF.
- Read address 1024 + 4·64 = 1280 (out of range) → rdata = 0, err = 1 with ready. Write to 1020 → dropped, err = 1, a later read of 1024 is unchanged.
- WAIT_CYCLES = 0 build: write 0x5 to 1032 then read it → freeze never rises, ready follows mem_r_en, rdata = 0x5 in the same cycle.
- Change address and wdata while in WAIT → they are ignored, and the originally latched address receives the originally latched data.
- Assert rst low in WAIT for a write of 0x1234 to 1036 → freeze drops immediately and a later read of 1036 returns the pre-write value.
- mem_r_en = mem_w_en = 1 with wdata 0xA5 to 1040 → treated as a write; a later read returns 0xA5 and rdata is unchanged during the write.
